serial_sub_unit: RTL and testbench

SERIAL_SUB_UNIT -- requirements
Module: serial_sub_unit

---
 rtl/serial_sub_unit_pkg.sv | 18 +
 rtl/serial_sub_unit_sub_slice.sv | 25 ++
 rtl/serial_sub_unit.sv | 126 ++++++++++++
 tb/tb_serial_sub_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_unit_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the controller state encoding and the step-counter width function.
package serial_sub_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold the values 0..n, so the counter never wraps
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_sub_unit_sub_slice.sv
// Combinational STEP-bit ripple-borrow subtract slice: diff = x - y - bin.
// Holds no state; the owning unit supplies and stores the running borrow.
module sub_slice #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] x,
    input  logic [STEP-1:0] y,
    input  logic            bin,
    output logic [STEP-1:0] diff,
    output logic            bout
);

    logic br;

    always_comb begin
        diff = '0;
        br   = bin;
        for (int i = 0; i < STEP; i++) begin
            diff[i] = x[i] ^ y[i] ^ br;
            br      = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/serial_sub_unit.sv
// Serial subtractor: computes a - b - bin over WIDTH/STEP cycles, STEP bits per cycle,
// and publishes difference, borrow, overflow and zero flags together on completion.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | waiting for start; last result held on outputs
//   ST_RUN  | one STEP-bit slice subtracted per cycle, busy high
//   ST_DONE | result just published, done high for one cycle; start accepted
module serial_sub_unit
    import serial_sub_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % STEP) != 0 || WIDTH < 2 || WIDTH > 64) begin : g_param_check
        $error("serial_sub_unit: WIDTH must be 2..64 and a multiple of STEP");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic [STEP-1:0]  s_diff;
    logic             s_bout;

    sub_slice #(
        .STEP (STEP)
    ) u_slice (
        .x    (a_sh[STEP-1:0]),
        .y    (b_sh[STEP-1:0]),
        .bin  (br),
        .diff (s_diff),
        .bout (s_bout)
    );

    // Difference bits enter at the top and walk down, so after N steps
    // the accumulator holds the full result in natural bit order.
    if (STEP == WIDTH) begin : g_acc_single
        assign acc_next = s_diff;
    end else begin : g_acc_shift
        assign acc_next = {s_diff, acc[WIDTH-1:STEP]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        acc   <= '0;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> STEP;
                    b_sh <= b_sh >> STEP;
                    br   <= s_bout;
                    acc  <= acc_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        d     <= acc_next;
                        bout  <= s_bout;
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ acc_next[WIDTH-1]);
                        zero  <= (acc_next == '0);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed bench for serial_sub_unit: an 8-bit/1-bit-step instance and a 16-bit/4-bit-step instance.
module tb_serial_sub_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        bin8 = 1'b0;
    logic        busy8, done8, bout8, ovf8, zero8;
    logic [7:0]  d8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        bin16 = 1'b0;
    logic        busy16, done16, bout16, ovf16, zero16;
    logic [15:0] d16;

    int passed = 0;
    int total  = 0;
    int lat, bc;
    bit seen_done;

    always #5 clk = ~clk;

    serial_sub_unit #(.WIDTH(8), .STEP(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8), .zero(zero8)
    );

    serial_sub_unit #(.WIDTH(16), .STEP(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .d(d16), .bout(bout16), .ovf(ovf16), .zero(zero16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Launch one 8-bit op, scramble inputs after acceptance, count edges to done and busy cycles.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic bi, input bit sync,
                       output int l, output int busy_n);
        if (sync) begin
            @(posedge clk);
            #1;
        end
        a8 = x; b8 = y; bin8 = bi; start8 = 1'b1;
        l = 0; busy_n = 0;
        do begin
            @(posedge clk);
            #1;
            if (l == 0) begin
                start8 = 1'b0; a8 = ~x; b8 = ~y; bin8 = ~bi;
            end
            l++;
            if (busy8) busy_n++;
        end while (!done8 && l < 40);
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic bi, output int l);
        @(posedge clk);
        #1;
        a16 = x; b16 = y; bin16 = bi; start16 = 1'b1;
        l = 0;
        do begin
            @(posedge clk);
            #1;
            if (l == 0) begin
                start16 = 1'b0; a16 = ~x; b16 = ~y;
            end
            l++;
        end while (!done16 && l < 40);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_d", d8, 8'h00);
        chk("rst_flags", {bout8, ovf8, zero8}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 1'b0, 1'b1, lat, bc);
        chk("05-03_lat", lat, 9);
        chk("05-03_busy", bc, 8);
        chk("05-03_d", d8, 8'h02);
        chk("05-03_flags", {bout8, ovf8, zero8}, 3'b000);

        op8(8'h03, 8'h05, 1'b0, 1'b1, lat, bc);
        chk("03-05_d", d8, 8'hFE);
        chk("03-05_bout_ovf", {bout8, ovf8}, 2'b10);

        op8(8'h00, 8'h00, 1'b1, 1'b1, lat, bc);
        chk("00-00-1_d", d8, 8'hFF);
        chk("00-00-1_bout", bout8, 1'b1);

        op8(8'h80, 8'h01, 1'b0, 1'b1, lat, bc);
        chk("80-01_d", d8, 8'h7F);
        chk("80-01_ovf_bout", {ovf8, bout8}, 2'b10);

        op8(8'h42, 8'h42, 1'b0, 1'b1, lat, bc);
        chk("42-42_d", d8, 8'h00);
        chk("42-42_zero", zero8, 1'b1);
        @(posedge clk);
        #1;
        chk("hold_done_low", done8, 1'b0);
        chk("hold_busy_low", busy8, 1'b0);
        chk("hold_d", {d8, zero8}, {8'h00, 1'b1});

        // Second start during RUN with different operands must be ignored
        @(posedge clk);
        #1;
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start8 = (lat == 3);
            if (lat == 3) begin
                a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
            end
        end while (!done8 && lat < 40);
        start8 = 1'b0;
        chk("run_start_lat", lat, 9);
        chk("run_start_d", d8, 8'h0F);

        // Start asserted during the DONE cycle
        op8(8'h20, 8'h05, 1'b1, 1'b0, lat, bc);
        chk("done_start_lat", lat, 9);
        chk("done_start_d", d8, 8'h1A);
        chk("done_start_flags", {bout8, ovf8, zero8}, 3'b000);

        // Abort in RUN cycle 4
        @(posedge clk);
        #1;
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start8 = 1'b0;
        end
        chk("pre_abort_busy", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_done", {busy8, done8}, 2'b00);
        chk("abort_d", d8, 8'h00);
        chk("abort_flags", {bout8, ovf8, zero8}, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) seen_done = 1'b1;
        end
        chk("abort_no_done", seen_done, 1'b0);

        op8(8'h09, 8'h04, 1'b0, 1'b1, lat, bc);
        chk("post_abort_lat", lat, 9);
        chk("post_abort_d", d8, 8'h05);

        op16(16'h1234, 16'h0235, 1'b0, lat);
        chk("w16_lat", lat, 5);
        chk("w16_d", d16, 16'h0FFF);
        chk("w16_bout", bout16, 1'b0);

        op16(16'h0000, 16'h0001, 1'b0, lat);
        chk("w16_wrap_d", d16, 16'hFFFF);
        chk("w16_wrap_bout", bout16, 1'b1);

        op16(16'h8000, 16'h7FFF, 1'b1, lat);
        chk("w16_ovf_d", d16, 16'h0000);
        chk("w16_ovf_flags", {ovf16, zero16, bout16}, 3'b110);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
